reg_write_arbiter: RTL and testbench



---
 rtl/reg_write_arbiter.sv | 157 +++++++++++++++
 tb/tb_reg_write_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: two-port valid/ready write arbiter that owns the configuration
// register bank.
//
// Arbitration is round-robin. A requester can hold a lock to keep the grant for an
// atomic burst, and an idle lock owner is released after LOCK_TIMEOUT cycles.
// A transfer to an address outside the bank writes no register and bumps err_count.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s0_* / s1_*                write request ports (valid, ready, addr, data, lock)
//   reg_out                    register bank, register i at bits [8i+7:8i]
//   wr_strobe                  one-cycle pulse after each in-range write
//   wr_src, wr_addr_q          port and address of the last in-range write
//   err_count                  saturating count of out-of-range transfers
//   lock_to                    sticky flag: a lock was released by timeout
module reg_write_arbiter #(
  parameter int unsigned NUM_REGS     = 5,
  parameter int unsigned LOCK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s0_valid,
  output logic                  s0_ready,
  input  logic [6:0]            s0_addr,
  input  logic [7:0]            s0_data,
  input  logic                  s0_lock,
  input  logic                  s1_valid,
  output logic                  s1_ready,
  input  logic [6:0]            s1_addr,
  input  logic [7:0]            s1_data,
  input  logic                  s1_lock,
  output logic [8*NUM_REGS-1:0] reg_out,
  output logic                  wr_strobe,
  output logic                  wr_src,
  output logic [6:0]            wr_addr_q,
  output logic [7:0]            err_count,
  output logic                  lock_to
);

  typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_e;

  localparam logic [7:0] ToLast   = 8'(LOCK_TIMEOUT - 1);
  localparam logic [6:0] NumRegsA = 7'(NUM_REGS);

  state_e     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic [7:0] to_cnt_q, to_cnt_d;
  logic       lock_to_q, lock_to_d;

  logic       gnt0, gnt1, xfer, addr_ok;
  logic [6:0] x_addr;
  logic [7:0] x_data;
  logic       x_lock;

  logic [7:0] regs_q [NUM_REGS];
  logic       wr_strobe_q, wr_src_q;
  logic [6:0] last_addr_q;
  logic [7:0] err_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= 1'b0;
      to_cnt_q  <= '0;
      lock_to_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      to_cnt_q  <= to_cnt_d;
      lock_to_q <= lock_to_d;
    end
  end

  // Grant: depends only on state, ptr and the two valids so ready never
  // combinationally follows addr, data or lock.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state_q)
      StIdle: begin
        gnt0 = s0_valid & (~s1_valid | ~ptr_q);
        gnt1 = s1_valid & (~s0_valid | ptr_q);
      end
      StLock0: gnt0 = s0_valid;
      StLock1: gnt1 = s1_valid;
      default: ;
    endcase
  end

  assign s0_ready = gnt0;
  assign s1_ready = gnt1;
  assign xfer     = gnt0 | gnt1;
  assign x_addr   = gnt1 ? s1_addr : s0_addr;
  assign x_data   = gnt1 ? s1_data : s0_data;
  assign x_lock   = gnt1 ? s1_lock : s0_lock;
  assign addr_ok  = x_addr < NumRegsA;

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    to_cnt_d  = to_cnt_q;
    lock_to_d = lock_to_q;
    if (xfer) begin
      to_cnt_d = '0;
      if (x_lock) begin
        state_d = gnt1 ? StLock1 : StLock0;
      end else begin
        state_d = StIdle;
        ptr_d   = ~gnt1;
      end
    end else if (state_q != StIdle) begin
      // In a lock state no transfer means the owner is not valid.
      if (to_cnt_q == ToLast) begin
        state_d   = StIdle;
        ptr_d     = (state_q == StLock0);
        lock_to_d = 1'b1;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + 8'd1;
      end
    end
  end

  // Register bank and write reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_strobe_q <= 1'b0;
      wr_src_q    <= 1'b0;
      last_addr_q <= '0;
      err_q       <= '0;
    end else begin
      wr_strobe_q <= xfer & addr_ok;
      if (xfer && addr_ok) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (x_addr == 7'(i)) regs_q[i] <= x_data;
        end
        wr_src_q    <= gnt1;
        last_addr_q <= x_addr;
      end
      if (xfer && !addr_ok && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[8*g +: 8] = regs_q[g];
  end

  assign wr_strobe = wr_strobe_q;
  assign wr_src    = wr_src_q;
  assign wr_addr_q = last_addr_q;
  assign err_count = err_q;
  assign lock_to   = lock_to_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: the driver models arbitration and the
// register bank abstractly, pushes one expected output record per cycle, and a
// separate monitor pops and compares after each rising edge.
module tb_reg_write_arbiter;
  localparam int NR = 5;
  localparam int LT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s0_valid = 0, s0_lock = 0, s1_valid = 0, s1_lock = 0;
  logic        s0_ready, s1_ready;
  logic [6:0]  s0_addr = '0, s1_addr = '0;
  logic [7:0]  s0_data = '0, s1_data = '0;
  logic [39:0] reg_out;
  logic        wr_strobe, wr_src, lock_to;
  logic [6:0]  wr_addr_q;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  reg_write_arbiter #(.NUM_REGS(NR), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
    .s0_lock(s0_lock),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
    .s1_lock(s1_lock),
    .reg_out(reg_out), .wr_strobe(wr_strobe), .wr_src(wr_src), .wr_addr_q(wr_addr_q),
    .err_count(err_count), .lock_to(lock_to)
  );

  typedef struct packed {
    logic        strobe;
    logic        src;
    logic [6:0]  addr;
    logic [39:0] regs;
    logic [7:0]  err;
    logic        lto;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  int         owner;   // -1: no lock holder
  int         prio;
  int         idle;
  logic [7:0] m_regs [NR];
  int         m_src;
  int         m_addr;
  int         m_err;
  int         m_lto;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1; prio = 0; idle = 0;
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    m_src = 0; m_addr = 0; m_err = 0; m_lto = 0;
  endtask

  function automatic logic [39:0] image();
    logic [39:0] r;
    for (int i = 0; i < NR; i++) r[8*i +: 8] = m_regs[i];
    return r;
  endfunction

  // One cycle: drive, check ready against the model, predict the next outputs.
  task automatic step(input bit v0, input logic [6:0] a0, input logic [7:0] d0, input bit l0,
                      input bit v1, input logic [6:0] a1, input logic [7:0] d1, input bit l1);
    int g;
    int a;
    exp_t e;
    @(negedge clk);
    s0_valid = v0; s0_addr = a0; s0_data = d0; s0_lock = l0;
    s1_valid = v1; s1_addr = a1; s1_data = d1; s1_lock = l1;
    #1;
    g = -1;
    if (owner >= 0) begin
      if ((owner == 0 && v0) || (owner == 1 && v1)) g = owner;
    end else if (v0 && v1) g = prio;
    else if (v0) g = 0;
    else if (v1) g = 1;
    chk("s0_ready", s0_ready, 64'(g == 0));
    chk("s1_ready", s1_ready, 64'(g == 1));
    e.strobe = 1'b0;
    if (g >= 0) begin
      a = (g == 1) ? int'(a1) : int'(a0);
      if (a < NR) begin
        m_regs[a] = (g == 1) ? d1 : d0;
        m_src = g; m_addr = a; e.strobe = 1'b1;
      end else if (m_err < 255) m_err++;
      idle = 0;
      if ((g == 1) ? l1 : l0) owner = g;
      else begin owner = -1; prio = 1 - g; end
    end else if (owner >= 0) begin
      idle++;
      if (idle == LT) begin prio = 1 - owner; owner = -1; idle = 0; m_lto = 1; end
    end
    e.src = 1'(m_src); e.addr = 7'(m_addr); e.regs = image();
    e.err = 8'(m_err); e.lto = 1'(m_lto);
    sb.push_back(e);
  endtask

  task automatic do_reset(input bit hold1);
    @(negedge clk);
    s1_valid = hold1; s1_lock = hold1; s1_addr = 7'd1; s1_data = 8'hEE;
    rst_n = 1'b0;
    #1;
    chk("rst_reg_out", reg_out, 0);
    chk("rst_wr_strobe", wr_strobe, 0);
    chk("rst_wr_src", wr_src, 0);
    chk("rst_wr_addr", wr_addr_q, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_lock_to", lock_to, 0);
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    s1_valid = 0; s1_lock = 0;
    rst_n = 1'b1;
  endtask

  // Monitor: one expected record per cycle after reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n) begin
        if (sb.size() == 0) begin
          chk("strobe_unexpected", wr_strobe, 0);
        end else begin
          e = sb.pop_front();
          chk("wr_strobe", wr_strobe, e.strobe);
          chk("wr_src", wr_src, e.src);
          chk("wr_addr_q", wr_addr_q, e.addr);
          chk("reg_out", reg_out, e.regs);
          chk("err_count", err_count, e.err);
          chk("lock_to", lock_to, e.lto);
        end
      end
    end
  end

  function automatic logic [6:0] rand_addr();
    if ($urandom_range(7, 0) == 0) return 7'($urandom_range(127, NR));
    return 7'($urandom_range(NR - 1, 0));
  endfunction

  initial begin
    int p0, p1;
    int pct [3];
    pct[0] = 0; pct[1] = 30; pct[2] = 90;
    model_reset();
    do_reset(1'b0);

    // Single write.
    step(1, 7'd2, 8'hA5, 0, 0, 7'd0, 8'h00, 0);

    // Alternation, both valid, no lock.
    for (int i = 0; i < 4; i++) step(1, 7'd0, 8'(8'h10 + i), 0, 1, 7'd1, 8'(8'h20 + i), 0);

    // Port 1 locked burst while port 0 keeps requesting.
    step(0, 7'd0, 8'h00, 0, 1, 7'd4, 8'h80, 1);
    step(1, 7'd0, 8'h31, 0, 1, 7'd3, 8'h7F, 0);
    step(1, 7'd0, 8'h32, 0, 0, 7'd0, 8'h00, 0);

    // Port 0 takes the lock then goes idle; port 1 waits for the timeout.
    step(1, 7'd2, 8'h11, 1, 0, 7'd0, 8'h00, 0);
    for (int i = 0; i < LT + 4; i++) step(0, 7'd0, 8'h00, 0, 1, 7'd1, 8'(i), 0);

    // Out-of-range flood saturates err_count.
    for (int i = 0; i < 300; i++) begin
      p0 = $urandom_range(2, 0);
      step(p0 != 1, ($urandom_range(1, 0) != 0) ? 7'd5 : 7'd127, 8'($urandom), 0,
           p0 != 0, ($urandom_range(1, 0) != 0) ? 7'd5 : 7'd127, 8'($urandom), 0);
    end

    // Reset in the middle of a port 1 locked burst.
    for (int i = 0; i < 3; i++) step(0, 7'd0, 8'h00, 0, 1, 7'd0, 8'(8'h33 + i), 1);
    do_reset(1'b1);
    step(1, 7'd1, 8'h44, 0, 1, 7'd2, 8'h55, 0);

    // Random traffic with varying per-port activity.
    for (int c = 0; c < 15; c++) begin
      p0 = pct[$urandom_range(2, 0)];
      p1 = pct[$urandom_range(2, 0)];
      for (int i = 0; i < 100; i++) begin
        step($urandom_range(99, 0) < p0, rand_addr(), 8'($urandom), $urandom_range(2, 0) == 0,
             $urandom_range(99, 0) < p1, rand_addr(), 8'($urandom), $urandom_range(2, 0) == 0);
      end
    end
    step(0, 7'd0, 8'h00, 0, 0, 7'd0, 8'h00, 0);

    repeat (2) @(posedge clk);
    #4;
    chk("scoreboard_drained", 64'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
